// File: rtl/mcs51_pkg.sv
// Shared encodings and defaults for the 8051 core blocks.
package mcs51_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_PER = 1'b1
    } owner_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam int DEF_MAX_WAIT = 4;
    localparam int DEF_LOCK_MAX = 3;

endpackage

// File: rtl/ram_arbiter.sv
// Shares the internal data RAM port between the CPU (fixed priority, lockable) and a peripheral.
// Latency: grant and RAM command in the request cycle; read data returns one cycle later.
// Backpressure: a denied requester holds req until gnt; peripheral starvation is bounded by MAX_WAIT.
module ram_arbiter
    import mcs51_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic          cpu_lock,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          per_req,
    input  logic          per_we,
    input  logic [AW-1:0] per_addr,
    input  logic [DW-1:0] per_wdata,
    output logic          per_gnt,
    output logic          per_rvalid,
    output logic [DW-1:0] per_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [2:0] LOCK_MAX_C = 3'(LOCK_MAX);

    state_e        state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic [2:0]    lock_cnt_q, lock_cnt_d;
    owner_e        owner_q, owner_d;
    logic          rd_pend_q, rd_pend_d;
    logic [DW-1:0] cpu_rdata_q, per_rdata_q;
    logic          per_starved;

    assign per_starved = per_req && (wait_cnt_q == MAX_WAIT_C);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // In LOCKED every cpu_req is granted, so "granted with lock=0" reduces to !cpu_lock.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_gnt && cpu_lock) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (!cpu_req || !cpu_lock || ((lock_cnt_q + 3'd1) == LOCK_MAX_C)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_gnt = 1'b0;
        per_gnt = 1'b0;
        unique case (state_q)
            ST_LOCKED: begin
                cpu_gnt = cpu_req;
            end
            default: begin
                per_gnt = per_starved || (per_req && !cpu_req);
                cpu_gnt = cpu_req && !per_starved;
            end
        endcase

        ram_en    = cpu_gnt || per_gnt;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (cpu_gnt) begin
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (per_gnt) begin
            ram_we    = per_we;
            ram_addr  = per_addr;
            ram_wdata = per_wdata;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!per_req || per_gnt) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        lock_cnt_d = lock_cnt_q;
        if (state_d == ST_IDLE) begin
            lock_cnt_d = 3'd0;
        end else if (state_q == ST_LOCKED && cpu_gnt) begin
            lock_cnt_d = lock_cnt_q + 3'd1;
        end

        rd_pend_d = (cpu_gnt && !cpu_we) || (per_gnt && !per_we);
        owner_d   = owner_q;
        if (rd_pend_d) owner_d = per_gnt ? OWN_PER : OWN_CPU;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= 4'd0;
            lock_cnt_q <= 3'd0;
            owner_q    <= OWN_CPU;
            rd_pend_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            owner_q    <= owner_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    // Read data is forwarded straight from the RAM in the return cycle and held afterwards.
    assign cpu_rvalid = rd_pend_q && (owner_q == OWN_CPU);
    assign per_rvalid = rd_pend_q && (owner_q == OWN_PER);
    assign cpu_rdata  = cpu_rvalid ? ram_rdata : cpu_rdata_q;
    assign per_rdata  = per_rvalid ? ram_rdata : per_rdata_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpu_rdata_q <= '0;
            per_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) cpu_rdata_q <= ram_rdata;
            if (per_rvalid) per_rdata_q <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a rule-level scoreboard checked every cycle.
module tb_ram_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int LOCK_MAX = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, cpu_lock;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_gnt, cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       per_req, per_we;
    logic [7:0] per_addr, per_wdata;
    logic       per_gnt, per_rvalid;
    logic [7:0] per_rdata;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata;
    logic [7:0] ram_rdata = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    ram_arbiter #(.AW(8), .DW(8), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .per_req(per_req), .per_we(per_we),
        .per_addr(per_addr), .per_wdata(per_wdata),
        .per_gnt(per_gnt), .per_rvalid(per_rvalid), .per_rdata(per_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        case (a)
            8'h30:   return 8'h5A;
            8'h20:   return 8'h20;
            8'h10:   return 8'hA0;
            8'h11:   return 8'hA1;
            8'h12:   return 8'hA2;
            default: return a ^ 8'h3C;
        endcase
    endfunction

    // Synchronous RAM seen by the arbiter
    logic [7:0] ram_mem [int];
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) ram_mem[int'(ram_addr)] = ram_wdata;
            else ram_rdata <= ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : init_val(ram_addr);
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chks(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", name, act, exp);
        end
    endtask

    // Scoreboard: requester-view memory, pending read and the arbitration rules
    logic [7:0] ref_mem [int];
    bit         m_locked;
    int         m_wait, m_lk;
    bit         m_pend, m_pend_per;
    logic [7:0] m_pend_dat, m_cpu_rd, m_per_rd;
    int         g;
    logic       e_cv, e_pv, e_we;
    logic [7:0] e_crd, e_prd, e_addr, e_wdat;

    always @(negedge clock) begin
        if (!reset) begin
            m_locked = 0; m_wait = 0; m_lk = 0;
            m_pend = 0; m_pend_per = 0; m_pend_dat = 8'h00;
            m_cpu_rd = 8'h00; m_per_rd = 8'h00;
            chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
            chk1("rst_per_rvalid", per_rvalid, 1'b0);
        end else begin
            e_cv  = m_pend && !m_pend_per;
            e_pv  = m_pend && m_pend_per;
            e_crd = e_cv ? m_pend_dat : m_cpu_rd;
            e_prd = e_pv ? m_pend_dat : m_per_rd;

            if (m_locked)                          g = cpu_req ? 1 : 0;
            else if (per_req && m_wait == MAX_WAIT) g = 2;
            else if (cpu_req)                      g = 1;
            else if (per_req)                      g = 2;
            else                                   g = 0;

            e_we   = (g == 1) ? cpu_we    : (g == 2) ? per_we    : 1'b0;
            e_addr = (g == 1) ? cpu_addr  : (g == 2) ? per_addr  : 8'h00;
            e_wdat = (g == 1) ? cpu_wdata : (g == 2) ? per_wdata : 8'h00;

            chk1("cpu_gnt", cpu_gnt, g == 1);
            chk1("per_gnt", per_gnt, g == 2);
            chk1("ram_en", ram_en, g != 0);
            chk1("ram_we", ram_we, e_we);
            chk8("ram_addr", ram_addr, e_addr);
            chk8("ram_wdata", ram_wdata, e_wdat);
            chk1("cpu_rvalid", cpu_rvalid, e_cv);
            chk8("cpu_rdata", cpu_rdata, e_crd);
            chk1("per_rvalid", per_rvalid, e_pv);
            chk8("per_rdata", per_rdata, e_prd);

            m_cpu_rd = e_crd;
            m_per_rd = e_prd;
            m_pend   = (g != 0) && !e_we;
            if (m_pend) begin
                m_pend_per = (g == 2);
                m_pend_dat = ref_mem.exists(int'(e_addr)) ? ref_mem[int'(e_addr)] : init_val(e_addr);
            end
            if (g != 0 && e_we) ref_mem[int'(e_addr)] = e_wdat;

            if (per_req && g != 2) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
            else                   m_wait = 0;

            if (m_locked) begin
                if (g == 1) m_lk++;
                if (!cpu_req || !cpu_lock || m_lk == LOCK_MAX) begin
                    m_locked = 0;
                    m_lk     = 0;
                end
            end else if (g == 1 && cpu_lock) begin
                m_locked = 1;
                m_lk     = 0;
            end
        end
    end

    task automatic drive(input logic cr, input logic cw, input logic cl, input logic [7:0] ca,
                         input logic [7:0] cd, input logic pr, input logic pw,
                         input logic [7:0] pa, input logic [7:0] pd);
        @(posedge clock);
        #1;
        cpu_req = cr; cpu_we = cw; cpu_lock = cl; cpu_addr = ca; cpu_wdata = cd;
        per_req = pr; per_we = pw; per_addr = pa; per_wdata = pd;
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    function automatic string gch();
        return cpu_gnt ? "C" : (per_gnt ? "P" : "-");
    endfunction

    string s;

    initial begin
        reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        per_req = 0; per_we = 0; per_addr = 8'h00; per_wdata = 8'h00;
        repeat (2) @(posedge clock);
        #3;
        chk1("reset_cpu_gnt", cpu_gnt, 1'b0);
        chk1("reset_per_gnt", per_gnt, 1'b0);
        chk1("reset_ram_en", ram_en, 1'b0);
        chk8("reset_ram_addr", ram_addr, 8'h00);
        chk8("reset_cpu_rdata", cpu_rdata, 8'h00);
        chk8("reset_per_rdata", per_rdata, 8'h00);
        reset = 1'b1;
        idle(2);

        // Lone CPU read
        drive(1, 0, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00);
        chk1("t1_cpu_gnt", cpu_gnt, 1'b1);
        chk1("t1_ram_en", ram_en, 1'b1);
        chk8("t1_ram_addr", ram_addr, 8'h30);
        idle(1);
        chk1("t1_cpu_rvalid", cpu_rvalid, 1'b1);
        chk8("t1_cpu_rdata", cpu_rdata, 8'h5A);
        chk1("t1_per_rvalid", per_rvalid, 1'b0);
        chk8("t1_per_rdata", per_rdata, 8'h00);
        idle(1);

        // Continuous contention: starvation bound
        s = "";
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 8'h40 + 8'(i), 8'h00, 1, 0, 8'h60, 8'h00);
            s = {s, gch()};
        end
        chks("t2_pattern", s, "CCCCPCCCCP");
        idle(2);

        // Locked read-modify-write while the peripheral saturates
        s = "";
        repeat (3) begin
            drive(1, 0, 0, 8'h40, 8'h00, 1, 0, 8'h50, 8'h00);
            s = {s, gch()};
        end
        drive(1, 0, 1, 8'h20, 8'h00, 1, 0, 8'h50, 8'h00);
        s = {s, gch()};
        drive(1, 1, 0, 8'h20, 8'h21, 1, 0, 8'h50, 8'h00);
        s = {s, gch()};
        chk8("t3_rmw_rdata", cpu_rdata, 8'h20);
        chk1("t3_per_blocked", per_gnt, 1'b0);
        chk1("t3_ram_we", ram_we, 1'b1);
        chk8("t3_ram_wdata", ram_wdata, 8'h21);
        drive(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h50, 8'h00);
        s = {s, gch()};
        chk1("t3_per_gnt_after", per_gnt, 1'b1);
        chks("t3_pattern", s, "CCCCCP");
        idle(1);
        drive(1, 0, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
        idle(1);
        chk8("t3_readback", cpu_rdata, 8'h21);
        idle(1);

        // Lock held too long
        s = "";
        repeat (6) begin
            drive(1, 0, 1, 8'h44, 8'h00, 1, 0, 8'h55, 8'h00);
            s = {s, gch()};
        end
        chks("t4_pattern", s, "CCCCPC");
        idle(2);

        // Alternating reads routed to their owners
        drive(1, 0, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h11, 8'h00);
        chk1("t5_c0_rvalid", cpu_rvalid, 1'b1);
        chk8("t5_c0_rdata", cpu_rdata, 8'hA0);
        chk1("t5_p0_rvalid", per_rvalid, 1'b0);
        drive(1, 0, 0, 8'h12, 8'h00, 0, 0, 8'h00, 8'h00);
        chk1("t5_p1_rvalid", per_rvalid, 1'b1);
        chk8("t5_p1_rdata", per_rdata, 8'hA1);
        chk1("t5_c1_rvalid", cpu_rvalid, 1'b0);
        chk8("t5_c1_hold", cpu_rdata, 8'hA0);
        idle(1);
        chk1("t5_c2_rvalid", cpu_rvalid, 1'b1);
        chk8("t5_c2_rdata", cpu_rdata, 8'hA2);
        chk8("t5_p2_hold", per_rdata, 8'hA1);
        idle(1);

        // Reset while a peripheral read is outstanding
        drive(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h11, 8'h00);
        chk1("t6_per_gnt", per_gnt, 1'b1);
        reset = 1'b0;
        idle(1);
        chk1("t6_rvalid_in_reset", per_rvalid, 1'b0);
        chk8("t6_rdata_in_reset", per_rdata, 8'h00);
        idle(1);
        reset = 1'b1;
        idle(1);
        chk1("t6_rvalid_after", per_rvalid, 1'b0);
        chk1("t6_ram_idle", ram_en, 1'b0);
        s = "";
        repeat (5) begin
            drive(1, 0, 0, 8'h70, 8'h00, 1, 0, 8'h71, 8'h00);
            s = {s, gch()};
        end
        chks("t6_pattern", s, "CCCCP");
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
